// File: rtl/sa_input_skewer.sv
// -----------------------------------------------------------------------------
// sa_input_skewer
//
// Upstream feeder for a fixed-weight, always-advancing systolic array.
// Each cycle it accepts one activation vector (or a zero bubble when in_valid
// is low) and delays row r by r cycles, so the array sees a diagonal
// wavefront. A parallel (valid, last) tag pipeline produces per-column result
// strobes and a frame-done pulse aligned with the array's bottom-row outputs.
// There is no backpressure: every chain shifts every cycle.
//
// Ports:
//   clk          rising-edge clock
//   resetn       asynchronous active-low reset (also resets the array)
//   in_valid     in_data carries a valid vector this cycle
//   in_data      activation vector; element r feeds array row r
//   in_last      last vector of a frame (ignored when in_valid=0)
//   sa_inputs    skewed vector driven into the array rows
//   col_valid    col_valid[c]: array output column c carries a result
//   col_last     col_last[c]: that result belongs to a last-tagged vector
//   frame_done   one-cycle pulse when the last column of a last vector is valid
//   busy         at least one valid vector is still in flight
//   frame_count  completed frames, modulo 2^FRAME_CNT_W
//
// SA_SIZE must be at least 2 so that every column tap is a register stage.
// -----------------------------------------------------------------------------
module sa_input_skewer #(
  parameter int SA_SIZE         = 8,
  parameter int ACTIVATION_SIZE = 8,
  parameter int FRAME_CNT_W     = 16
) (
  input  logic                                          clk,
  input  logic                                          resetn,
  input  logic                                          in_valid,
  input  logic [SA_SIZE-1:0][ACTIVATION_SIZE-1:0]       in_data,
  input  logic                                          in_last,
  output logic [SA_SIZE-1:0][ACTIVATION_SIZE-1:0]       sa_inputs,
  output logic [SA_SIZE-1:0]                            col_valid,
  output logic [SA_SIZE-1:0]                            col_last,
  output logic                                          frame_done,
  output logic                                          busy,
  output logic [FRAME_CNT_W-1:0]                        frame_count
);

  // Tag stages 0..TAG_DEPTH-1; stage 0 is the live input, the rest are flops.
  localparam int TAG_DEPTH = 2*SA_SIZE - 1;

  // Bubbles are forced to zero so they add nothing to any partial sum.
  logic [SA_SIZE-1:0][ACTIVATION_SIZE-1:0] gated_data;

  always_comb begin
    gated_data = '0;
    if (in_valid) gated_data = in_data;
  end

  // ---------------------------------------------------------------------------
  // Triangular skew: row r passes through an r-deep shift chain.
  // ---------------------------------------------------------------------------
  for (genvar r = 0; r < SA_SIZE; r++) begin : g_row
    if (r == 0) begin : g_direct
      assign sa_inputs[0] = gated_data[0];
    end else begin : g_chain
      logic [ACTIVATION_SIZE-1:0] chain [r];

      // NOTE: these are datapath registers, but they are still reset so that a
      // reset mid-frame injects zeros rather than stale activations into the
      // array, whose accumulators restart on the same reset.
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          for (int k = 0; k < r; k++) chain[k] <= '0;
        end else begin
          // NOTE: non-blocking assignments make every stage sample the old
          // value of its predecessor, which is what turns this into a shift
          // chain rather than a single wire.
          chain[0] <= gated_data[r];
          for (int k = 1; k < r; k++) chain[k] <= chain[k-1];
        end
      end

      assign sa_inputs[r] = chain[r-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Tag pipeline: (valid, last) pairs, stage d = stage 0 delayed by d cycles.
  // ---------------------------------------------------------------------------
  logic [TAG_DEPTH-1:1] tag_valid_q;
  logic [TAG_DEPTH-1:1] tag_last_q;
  logic [TAG_DEPTH-1:0] tag_valid;
  logic [TAG_DEPTH-1:0] tag_last;

  assign tag_valid = {tag_valid_q, in_valid};
  assign tag_last  = {tag_last_q,  in_valid & in_last};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tag_valid_q <= '0;
      tag_last_q  <= '0;
    end else begin
      tag_valid_q <= tag_valid[TAG_DEPTH-2:0];
      tag_last_q  <= tag_last[TAG_DEPTH-2:0];
    end
  end

  // Column c of the array produces its result SA_SIZE-1+c cycles after the
  // vector enters row 0, so the strobes are the taps at exactly that delay.
  assign col_valid  = tag_valid[TAG_DEPTH-1:SA_SIZE-1];
  assign col_last   = tag_last[TAG_DEPTH-1:SA_SIZE-1];
  assign frame_done = col_valid[SA_SIZE-1] & col_last[SA_SIZE-1];
  assign busy       = |tag_valid;

  // ---------------------------------------------------------------------------
  // Completed-frame counter, free-running modulo 2^FRAME_CNT_W.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      frame_count <= '0;
    end else if (frame_done) begin
      frame_count <= frame_count + FRAME_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sa_input_skewer.sv
// -----------------------------------------------------------------------------
// tb_sa_input_skewer
//
// Scoreboard bench for sa_input_skewer (SA_SIZE=4, ACTIVATION_SIZE=8,
// FRAME_CNT_W=2 so the counter wraps within a short run). Stimulus pushes
// hand-derived expectations tagged with the cycle they apply to; a monitor on
// the falling edge pops and compares every entry due in the current cycle.
// A small behavioural fixed-weight systolic array with identity weights sits
// on sa_inputs for the end-to-end alignment checks.
// -----------------------------------------------------------------------------
module tb_sa_input_skewer;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int FW = 2;

  typedef logic [N-1:0][AW-1:0] vec_t;

  typedef enum int {K_SA, K_CV, K_CL, K_FD, K_BUSY, K_FC, K_ARR} kind_t;

  typedef struct {
    int          cyc;
    kind_t       kind;
    int          idx;
    logic [31:0] val;
  } exp_t;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  vec_t          in_data = '0;
  vec_t          sa_inputs;
  logic [N-1:0]  col_valid;
  logic [N-1:0]  col_last;
  logic          frame_done;
  logic          busy;
  logic [FW-1:0] frame_count;

  sa_input_skewer #(
    .SA_SIZE        (N),
    .ACTIVATION_SIZE(AW),
    .FRAME_CNT_W    (FW)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .sa_inputs  (sa_inputs),
    .col_valid  (col_valid),
    .col_last   (col_last),
    .frame_done (frame_done),
    .busy       (busy),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  // Cycle k is the interval following the k-th rising edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Behavioural systolic array: activations move right, partial sums move
  // down, one register per hop, combinational PEs, identity weights.
  // ---------------------------------------------------------------------------
  logic [AW-1:0] a_reg [N][N];
  logic [31:0]   p_reg [N][N];
  logic [AW-1:0] a_in  [N][N];
  logic [31:0]   p_out [N][N];
  logic [31:0]   arr_out [N];

  always_comb begin
    a_in    = '{default: '0};
    p_out   = '{default: '0};
    arr_out = '{default: '0};
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        logic [31:0] p_in;
        if (c == 0) a_in[r][c] = sa_inputs[r];
        else        a_in[r][c] = a_reg[r][c-1];
        if (r == 0) p_in = '0;
        else        p_in = p_reg[r-1][c];
        p_out[r][c] = p_in + ((r == c) ? 32'(a_in[r][c]) : 32'd0);
      end
    end
    for (int c = 0; c < N; c++) arr_out[c] = p_out[N-1][c];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_reg <= '{default: '0};
      p_reg <= '{default: '0};
    end else begin
      a_reg <= a_in;
      p_reg <= p_out;
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  exp_t exp_q[$];
  int   base = 0;
  int   checks = 0;
  int   failures = 0;

  task automatic push(int rel, kind_t k, int idx, logic [31:0] v);
    exp_t e;
    e.cyc  = base + rel;
    e.kind = k;
    e.idx  = idx;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic check(string name, int idx, int at, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s[%0d] cycle %0d: got 0x%0h, expected 0x%0h", name, idx, at, act, expv);
    end
  endtask

  function automatic logic [31:0] actual(kind_t k, int idx);
    case (k)
      K_SA:    return 32'(sa_inputs[idx]);
      K_CV:    return 32'(col_valid);
      K_CL:    return 32'(col_last);
      K_FD:    return 32'(frame_done);
      K_BUSY:  return 32'(busy);
      K_FC:    return 32'(frame_count);
      K_ARR:   return arr_out[idx];
      default: return 32'hdead_beef;
    endcase
  endfunction

  // Monitor: compare everything due this cycle; anything overdue is a miss.
  always @(negedge clk) begin
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc == cyc) begin
        check(exp_q[i].kind.name(), exp_q[i].idx, cyc,
              actual(exp_q[i].kind, exp_q[i].idx), exp_q[i].val);
        exp_q.delete(i);
      end else if (exp_q[i].cyc < cyc) begin
        check({"missed_", exp_q[i].kind.name()}, exp_q[i].idx, exp_q[i].cyc,
              32'hffff_ffff, exp_q[i].val);
        exp_q.delete(i);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  function automatic vec_t mk(int e0, int e1, int e2, int e3);
    vec_t v;
    v[0] = AW'(e0);
    v[1] = AW'(e1);
    v[2] = AW'(e2);
    v[3] = AW'(e3);
    return v;
  endfunction

  task automatic step(logic v, logic l, vec_t d);
    @(posedge clk);
    #1;
    in_valid = v;
    in_last  = l;
    in_data  = d;
  endtask

  task automatic idle(int n);
    repeat (n) step(1'b0, 1'b0, '0);
  endtask

  task automatic do_reset(bit check_state);
    @(posedge clk);
    #1;
    resetn   = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    if (check_state) begin
      base = cyc;
      for (int r = 0; r < N; r++) push(0, K_SA, r, 0);
      push(0, K_CV, 0, 0);
      push(0, K_CL, 0, 0);
      push(0, K_FD, 0, 0);
      push(0, K_BUSY, 0, 0);
      push(0, K_FC, 0, 0);
    end
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed scenarios
  // ---------------------------------------------------------------------------
  initial begin
    do_reset(1'b1);

    // Single vector {1,2,3,4}, last-tagged, at cycle 0.
    base = cyc + 1;
    for (int k = 0; k <= 7; k++) begin
      logic [N-1:0] cv;
      for (int r = 0; r < N; r++) push(k, K_SA, r, (k == r) ? r + 1 : 0);
      for (int c = 0; c < N; c++) cv[c] = (k == 3 + c);
      push(k, K_CV, 0, 32'(cv));
      push(k, K_CL, 0, 32'(cv));
      push(k, K_FD, 0, (k == 6) ? 1 : 0);
      push(k, K_BUSY, 0, (k <= 6) ? 1 : 0);
    end
    push(6, K_FC, 0, 0);
    push(7, K_FC, 0, 1);
    step(1'b1, 1'b1, mk(1, 2, 3, 4));
    idle(9);

    // Two back-to-back 3-vector frames, cycles 0..5, last at 2 and 5.
    do_reset(1'b0);
    base = cyc + 1;
    for (int k = 0; k <= 12; k++) begin
      logic [N-1:0] cv;
      logic [N-1:0] cl;
      for (int c = 0; c < N; c++) begin
        cv[c] = (k >= 3 + c) && (k <= 8 + c);
        cl[c] = (k == 5 + c) || (k == 8 + c);
      end
      for (int r = 0; r < N; r++)
        push(k, K_SA, r, (k - r >= 0 && k - r <= 5) ? 16 * (k - r) + r + 1 : 0);
      push(k, K_CV, 0, 32'(cv));
      push(k, K_CL, 0, 32'(cl));
      push(k, K_FD, 0, (k == 8 || k == 11) ? 1 : 0);
      push(k, K_BUSY, 0, (k <= 11) ? 1 : 0);
    end
    push(9, K_FC, 0, 1);
    push(12, K_FC, 0, 2);
    for (int k = 0; k <= 5; k++)
      step(1'b1, (k == 2 || k == 5), mk(16 * k + 1, 16 * k + 2, 16 * k + 3, 16 * k + 4));
    idle(14);

    // Bubble at cycle 1 carrying 0xFF data and a stray in_last.
    do_reset(1'b0);
    base = cyc + 1;
    for (int r = 0; r < N; r++) begin
      push(r,     K_SA, r, 8'h11 + r);
      push(r + 1, K_SA, r, 0);
      push(r + 2, K_SA, r, 8'h31 + r);
    end
    push(1, K_BUSY, 0, 1);
    push(3, K_CV, 0, 4'b0001);
    push(4, K_CV, 0, 4'b0010);
    push(5, K_CV, 0, 4'b0101);
    push(3, K_CL, 0, 4'b0000);
    push(4, K_CL, 0, 4'b0000);
    push(5, K_CL, 0, 4'b0001);
    push(8, K_CL, 0, 4'b1000);
    push(6, K_FD, 0, 0);
    push(7, K_FD, 0, 0);
    push(8, K_FD, 0, 1);
    push(9, K_BUSY, 0, 0);
    push(9, K_FC, 0, 1);
    step(1'b1, 1'b0, mk(8'h11, 8'h12, 8'h13, 8'h14));
    step(1'b0, 1'b1, mk(8'hff, 8'hff, 8'hff, 8'hff));
    step(1'b1, 1'b1, mk(8'h31, 8'h32, 8'h33, 8'h34));
    idle(12);

    // Reset asserted mid-frame in cycle 4, released in cycle 5.
    do_reset(1'b0);
    base = cyc + 1;
    push(3, K_CV, 0, 4'b0001);
    push(3, K_BUSY, 0, 1);
    push(4, K_CV, 0, 0);
    push(4, K_CL, 0, 0);
    push(4, K_FD, 0, 0);
    push(4, K_BUSY, 0, 0);
    push(4, K_FC, 0, 0);
    for (int r = 0; r < N; r++) push(4, K_SA, r, 0);
    for (int k = 5; k <= 14; k++) begin
      push(k, K_CV, 0, 0);
      push(k, K_FD, 0, 0);
      push(k, K_BUSY, 0, 0);
    end
    push(14, K_FC, 0, 0);
    for (int k = 0; k <= 3; k++) step(1'b1, (k == 3), mk(k + 1, k + 2, k + 3, k + 4));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    resetn   = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    idle(10);

    // End-to-end through the identity-weight array: input {5,6,7,8}.
    do_reset(1'b0);
    base = cyc + 1;
    for (int c = 0; c < N; c++) begin
      push(2 + c, K_ARR, c, 0);
      push(3 + c, K_ARR, c, 5 + c);
      push(3 + c, K_CV, 0, 1 << c);
      push(4 + c, K_ARR, c, 0);
    end
    step(1'b1, 1'b1, mk(5, 6, 7, 8));
    idle(10);

    // Five single-vector frames back-to-back; 2-bit counter wraps.
    do_reset(1'b0);
    base = cyc + 1;
    push(6, K_FC, 0, 0);
    for (int j = 0; j < 5; j++) push(6 + j, K_FD, 0, 1);
    push(11, K_FD, 0, 0);
    push(7,  K_FC, 0, 1);
    push(8,  K_FC, 0, 2);
    push(9,  K_FC, 0, 3);
    push(10, K_FC, 0, 0);
    push(11, K_FC, 0, 1);
    for (int j = 0; j < 5; j++) step(1'b1, 1'b1, mk(j + 1, j + 2, j + 3, j + 4));
    idle(10);

    // Every pushed expectation must have been consumed by the monitor.
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
